instruction_fetch_queue: RTL



---
 rtl/cpu_pkg.sv | 36 +++
 rtl/instruction_fetch_queue_fetch_queue.sv | 53 +++++
 rtl/instruction_fetch_queue.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared RV32 front-end constants and types.
// Imported by fetch and decode stages.
package cpu_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  typedef enum logic [1:0] {
    FS_FETCH = 2'd0,
    FS_WAIT  = 2'd1,
    FS_DROP  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(
    input logic [XLEN-1:0] a
  );
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/instruction_fetch_queue_fetch_queue.sv
// fetch_queue: circular FIFO holding fetched instructions.
// Flush wins over push/pop; head reads zero when empty.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int W     = 64
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           push,
  input  logic [W-1:0]   wdata,
  input  logic           pop,
  input  logic           flush,
  output logic [W-1:0]   rdata,
  output logic [PTR_W:0] count,
  output logic           full,
  output logic           empty
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  assign rdata   = empty ? '0 : mem[head];

  always_ff @(posedge clock) begin
    if (do_push) mem[tail] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= tail;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + PTR_W'(1);
      if (do_pop)  head <= head + PTR_W'(1);
      count <= count
             + (PTR_W+1)'(do_push)
             - (PTR_W+1)'(do_pop);
    end
  end

endmodule

// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: PC, one-outstanding fetch FSM
// and in-order instruction queue feeding decode.
module instruction_fetch_queue
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  parameter int              QUEUE_DEPTH = 4,
  parameter int              PTR_W       = 2
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  output logic [INSTR_W-1:0] instr,
  output logic [XLEN-1:0]    instr_pc,
  output logic               available,
  input  logic               decode_take,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic [PTR_W:0]     queue_count
);

  fetch_state_e     state;
  fetch_state_e     state_n;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  req_pc;
  logic             outstanding;
  logic             armed;
  logic             accept;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [PTR_W+1:0] occ;
  fetch_entry_t     head_q;
  fetch_entry_t     push_q;

  assign occ = {1'b0, queue_count}
             + (PTR_W+2)'(outstanding);

  // armed keeps the request line low for one cycle after reset
  assign imem_req_valid = (state == FS_FETCH)
                        && armed
                        && !redirect_valid
                        && !full
                        && (occ < (PTR_W+2)'(QUEUE_DEPTH));

  assign accept    = imem_req_valid && imem_req_ready;
  assign imem_addr = pc;
  assign pop       = decode_take && !empty;
  assign available = !empty;
  assign instr     = head_q.instr;
  assign instr_pc  = head_q.pc;

  always_comb begin
    push_q       = '0;
    push_q.instr = imem_resp_data;
    push_q.pc    = req_pc;
  end

  always_comb begin
    state_n = state;
    push    = 1'b0;
    unique case (state)
      FS_FETCH: begin
        if (accept) state_n = FS_WAIT;
      end
      FS_WAIT: begin
        if (imem_resp_valid) begin
          push    = 1'b1;
          state_n = FS_FETCH;
        end
      end
      FS_DROP: begin
        if (imem_resp_valid) state_n = FS_FETCH;
      end
      default: state_n = FS_FETCH;
    endcase
    // a response landing with the redirect retires the request
    if (redirect_valid) begin
      if (outstanding && !imem_resp_valid)
        state_n = FS_DROP;
      else
        state_n = FS_FETCH;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= FS_FETCH;
      pc          <= RESET_PC;
      req_pc      <= RESET_PC;
      outstanding <= 1'b0;
      armed       <= 1'b0;
    end else begin
      state       <= state_n;
      armed       <= 1'b1;
      outstanding <= (state_n != FS_FETCH);
      if (accept) req_pc <= pc;
      if (redirect_valid)
        pc <= word_align(redirect_pc);
      else if (accept)
        pc <= pc + XLEN'(4);
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .PTR_W (PTR_W),
    .W     ($bits(fetch_entry_t))
  ) u_queue (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata (push_q),
    .pop   (pop),
    .flush (redirect_valid),
    .rdata (head_q),
    .count (queue_count),
    .full  (full),
    .empty (empty)
  );

endmodule
